// File: rtl/mem_resp_ctrl_pkg.sv
// Shared types and helpers for the data-memory responder: size encodings,
// FSM states, store lane merge and load sign extension.
package mem_resp_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, ACK} state_t;

  // Size 2'b10 falls into the default arm and behaves as a word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] wd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] r;
    r = old_w;
    case (size)
      SZ_BYTE: r[{lane, 3'b000} +: 8]     = wd[7:0];
      SZ_HALF: r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sign_ext(input logic [31:0] w,
                                           input logic [1:0]  size,
                                           input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: return {{24{b[7]}}, b};
      SZ_HALF: return {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_resp_ctrl_if.sv
// Request/response bus between the load/store unit (master) and the
// data-memory responder (slave).
interface mem_resp_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic [31:0] adr_i;
  logic [31:0] wd_i;
  logic [31:0] rd_o;
  logic        ack_o;
  logic        busy_o;
  logic        err_o;

  modport master (output req_i, we_i, size_i, adr_i, wd_i,
                  input  rd_o, ack_o, busy_o, err_o);
  modport slave  (input  req_i, we_i, size_i, adr_i, wd_i,
                  output rd_o, ack_o, busy_o, err_o);
endinterface

// File: rtl/mem_resp_ctrl_array.sv
// DEPTH x 32 word array with one write port and a registered read port.
// Contents are never reset.
module mem_resp_array #(
  parameter int unsigned DEPTH = 16384,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_resp_ctrl.sv
// Data-memory responder: one byte/half/word request at a time, sub-word
// stores by read-modify-write. Optional MISALIGN_CHECK_EN flags misalignment.
module mem_resp_ctrl
  import mem_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h0000_4000,
  parameter int unsigned DEPTH    = 16384
) (
  input  logic           clk_i,
  input  logic           reset_i,
  mem_resp_ctrl_if.slave bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  state_t          state, state_nxt;
  logic [31:0]     off;
  logic            in_range, misalign;
  logic            we_q, ok_q;
  logic [1:0]      size_q, lane_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wd_q;
  logic            mem_we;
  logic [31:0]     mem_wdata, mem_rdata, load_val, rd_hold;

  assign off      = bus.adr_i - BASE_ADR;
  assign in_range = {1'b0, off} < SPAN;

`ifdef MISALIGN_CHECK_EN
  logic mis_q;
  assign misalign = (bus.size_i == SZ_HALF && off[0]) ||
                    (bus.size_i[1] && off[1:0] != 2'b00);

  always_ff @(posedge clk_i) begin
    if (reset_i)                           mis_q <= 1'b0;
    else if (state == IDLE && bus.req_i)   mis_q <= misalign;
  end
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_i) state_nxt = (bus.we_i && bus.size_i[1]) ? WR : RD;
      RD:      state_nxt = we_q ? MRG : ACK;
      MRG:     state_nxt = ACK;
      WR:      state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      we_q   <= 1'b0;
      ok_q   <= 1'b0;
      size_q <= '0;
      lane_q <= '0;
      idx_q  <= '0;
      wd_q   <= '0;
    end else if (state == IDLE && bus.req_i) begin
      we_q   <= bus.we_i;
      ok_q   <= in_range && !misalign;
      size_q <= bus.size_i;
      lane_q <= off[1:0];
      idx_q  <= off[AW+1:2];
      wd_q   <= bus.wd_i;
    end
  end

  // A reset landing in MRG drops the merge write; a WR write is not gated
  // since it commits on the same edge the reset is sampled.
  assign mem_we    = ok_q && (state == WR || (state == MRG && !reset_i));
  assign mem_wdata = lane_merge(mem_rdata, wd_q, size_q, lane_q);
  assign load_val  = ok_q ? sign_ext(mem_rdata, size_q, lane_q) : '0;

  mem_resp_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk_i),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Read data lands in the ACK cycle; rd_hold keeps it visible afterwards.
  always_ff @(posedge clk_i) begin
    if (reset_i)                    rd_hold <= '0;
    else if (state == ACK && !we_q) rd_hold <= load_val;
  end

  always_comb begin
    bus.ack_o  = (state == ACK);
    bus.busy_o = (state != IDLE);
    bus.rd_o   = (state == ACK && !we_q) ? load_val : rd_hold;
`ifdef MISALIGN_CHECK_EN
    bus.err_o  = (state == ACK) && mis_q;
`else
    bus.err_o  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Self-checking bench for mem_resp_ctrl: directed scenarios plus random
// traffic against a byte-addressed reference memory.
module tb_mem_resp_ctrl;
  import mem_resp_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_4000;
  localparam int unsigned DEPTH = 16384;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  mem_resp_ctrl_if bus();

  mem_resp_ctrl #(.BASE_ADR(BASE), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_mem [int unsigned];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit access_ok(input logic [31:0] adr, input logic [1:0] sz);
    logic [31:0] off;
    off = adr - BASE;
    if (off >= DEPTH * 4) return 0;
`ifdef MISALIGN_CHECK_EN
    if (off % nbytes(sz) != 0) return 0;
`endif
    return 1;
  endfunction

  function automatic bit exp_err(input logic [31:0] adr, input logic [1:0] sz);
`ifdef MISALIGN_CHECK_EN
    logic [31:0] off;
    off = adr - BASE;
    return (off % nbytes(sz)) != 0;
`else
    return (adr & 32'h0) != 0 || sz == 2'b00 && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] adr, input logic [1:0] sz);
    logic [31:0] off, v;
    int unsigned n, base;
    if (!access_ok(adr, sz)) return 32'h0;
    off  = adr - BASE;
    n    = nbytes(sz);
    base = off - (off % n);
    v    = 32'h0;
    for (int unsigned i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    if (n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] adr, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] off;
    int unsigned n, base;
    if (!access_ok(adr, sz)) return;
    off  = adr - BASE;
    n    = nbytes(sz);
    base = off - (off % n);
    for (int unsigned i = 0; i < n; i++) ref_mem[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  task automatic xfer(input logic we, input logic [1:0] sz, input logic [31:0] adr,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd,
                      output logic err);
    bit done;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = we; bus.size_i = sz; bus.adr_i = adr; bus.wd_i = wd;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    lat = -1; rd = '0; err = 1'b0; done = 0;
    for (int k = 1; k <= 8 && !done; k++) begin
      if (bus.ack_o) begin
        lat = k; rd = bus.rd_o; err = bus.err_o; done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string tag, input logic we, input logic [1:0] sz,
                        input logic [31:0] adr, input logic [31:0] wd, output logic [31:0] rd);
    int lat, exp_lat;
    logic err;
    logic [31:0] exp_rd;
    exp_rd  = model_load(adr, sz);
    exp_lat = (we && nbytes(sz) < 4) ? 3 : 2;
    xfer(we, sz, adr, wd, lat, rd, err);
    check_eq({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    if (!we) check_eq({tag, ".rd"}, rd, exp_rd);
    check_eq({tag, ".err"}, {31'b0, err}, {31'b0, exp_err(adr, sz)});
    if (we) model_store(adr, sz, wd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [31:0] rdv, a;
    logic [1:0]  s;
    logic        w;
    int          acks;

    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'b00; bus.adr_i = '0; bus.wd_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.ack", {31'b0, bus.ack_o}, 32'h0);
    check_eq("rst.busy", {31'b0, bus.busy_o}, 32'h0);
    check_eq("rst.err", {31'b0, bus.err_o}, 32'h0);
    check_eq("rst.rd", bus.rd_o, 32'h0);
    @(negedge clk) reset = 1'b0;

    // 1: word store / load
    run_op("t1.sw", 1'b1, SZ_WORD, 32'h4000, 32'hDEAD_BEEF, rdv);
    run_op("t1.lw", 1'b0, SZ_WORD, 32'h4000, 32'h0, rdv);
    check_eq("t1.val", rdv, 32'hDEAD_BEEF);

    // 2: byte store merge
    run_op("t2.sw", 1'b1, SZ_WORD, 32'h4004, 32'h1122_3344, rdv);
    run_op("t2.sb", 1'b1, SZ_BYTE, 32'h4005, 32'h0000_0080, rdv);
    run_op("t2.lw", 1'b0, SZ_WORD, 32'h4004, 32'h0, rdv);
    check_eq("t2.lwv", rdv, 32'h1122_8044);
    run_op("t2.lb", 1'b0, SZ_BYTE, 32'h4005, 32'h0, rdv);
    check_eq("t2.lbv", rdv, 32'hFFFF_FF80);

    // 3: half store merge
    run_op("t3.sw", 1'b1, SZ_WORD, 32'h4004, 32'hAAAA_AAAA, rdv);
    run_op("t3.sh", 1'b1, SZ_HALF, 32'h4006, 32'h0000_1234, rdv);
    run_op("t3.lw", 1'b0, SZ_WORD, 32'h4004, 32'h0, rdv);
    check_eq("t3.lwv", rdv, 32'h1234_AAAA);
    run_op("t3.lh", 1'b0, SZ_HALF, 32'h4006, 32'h0, rdv);
    check_eq("t3.lhv", rdv, 32'h0000_1234);

    // 4: range boundaries
    run_op("t4.lo", 1'b0, SZ_WORD, 32'h3FFC, 32'h0, rdv);
    check_eq("t4.lov", rdv, 32'h0);
    run_op("t4.hi", 1'b1, SZ_WORD, 32'h0001_4000, 32'h5A5A_5A5A, rdv);
    run_op("t4.w0", 1'b0, SZ_WORD, 32'h4000, 32'h0, rdv);
    check_eq("t4.w0v", rdv, 32'hDEAD_BEEF);
    run_op("t4.lsw", 1'b1, SZ_WORD, 32'h0001_3FFC, 32'hC0FF_EE11, rdv);
    run_op("t4.llw", 1'b0, SZ_WORD, 32'h0001_3FFC, 32'h0, rdv);
    check_eq("t4.llv", rdv, 32'hC0FF_EE11);

    // 5: reset during MRG drops the store
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.size_i = SZ_BYTE; bus.adr_i = 32'h4004; bus.wd_i = 32'hFF;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    @(posedge clk); #1;
    check_eq("t5.mrg_ack", {31'b0, bus.ack_o}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("t5.ack", {31'b0, bus.ack_o}, 32'h0);
    check_eq("t5.busy", {31'b0, bus.busy_o}, 32'h0);
    check_eq("t5.rd", bus.rd_o, 32'h0);
    @(negedge clk) reset = 1'b0;
    run_op("t5.lw", 1'b0, SZ_WORD, 32'h4004, 32'h0, rdv);
    check_eq("t5.keep", rdv, 32'h1234_AAAA);
    run_op("t5.sb", 1'b1, SZ_BYTE, 32'h4004, 32'hFF, rdv);
    run_op("t5.lw2", 1'b0, SZ_WORD, 32'h4004, 32'h0, rdv);
    check_eq("t5.new", rdv, 32'h1234_AAFF);

    // reset during WR: the write already happened
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.size_i = SZ_WORD; bus.adr_i = 32'h4008; bus.wd_i = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("t5w.ack", {31'b0, bus.ack_o}, 32'h0);
    check_eq("t5w.busy", {31'b0, bus.busy_o}, 32'h0);
    @(negedge clk) reset = 1'b0;
    model_store(32'h4008, SZ_WORD, 32'h0BAD_F00D);
    run_op("t5w.lw", 1'b0, SZ_WORD, 32'h4008, 32'h0, rdv);
    check_eq("t5w.val", rdv, 32'h0BAD_F00D);

    // 6: req while busy is ignored
    acks = 0;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.size_i = SZ_WORD; bus.adr_i = 32'h4004; bus.wd_i = 32'h0;
    @(posedge clk); #1;
    bus.we_i = 1'b1; bus.wd_i = 32'h5555_5555;
    check_eq("t6.busy", {31'b0, bus.busy_o}, 32'h1);
    @(posedge clk); #1;
    if (bus.ack_o) acks++;
    rdv = bus.rd_o;
    @(negedge clk) bus.req_i = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.ack_o) acks++;
    end
    check_eq("t6.acks", 32'(acks), 32'd1);
    check_eq("t6.rd", rdv, 32'h1234_AAFF);
    run_op("t6.lw", 1'b0, SZ_WORD, 32'h4004, 32'h0, rdv);
    check_eq("t6.keep", rdv, 32'h1234_AAFF);

`ifdef MISALIGN_CHECK_EN
    run_op("mis.lw", 1'b0, SZ_WORD, 32'h4002, 32'h0, rdv);
    check_eq("mis.rd", rdv, 32'h0);
`endif

    // random traffic over a 16-word window
    for (int i = 0; i < 16; i++)
      run_op("init", 1'b1, SZ_WORD, BASE + 32'(4 * i), $urandom, rdv);
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       a = 32'h0000_3FFC;
          1:       a = 32'h0001_4000 + 32'($urandom_range(0, 255));
          2:       a = 32'h0000_0000;
          default: a = 32'hFFFF_FFF0;
        endcase
      end else begin
        a = BASE + 32'($urandom_range(0, 63));
      end
      run_op("rnd", w, s, a, $urandom, rdv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
